uart_tx_core: RTL

UART transmit core: accepts a byte over a valid/ready handshake, serialises it LSB-first as start/data/optional parity/stop bits, and advances one bit per baud tick. It is the transmit counterpart to the Rx core FSM and shares its one-hot state encoding. State, bit counter, stop counter and shift register are triplicated with 2-of-3 majority voting for SEU tolerance. It sits between the host byte interface and the baudrate generator.

---
 rtl/uart_tx_core.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART transmit core with majority-voted FSM, counters and shift register
// Holding register feeds a triplicated serialiser; every clock rewrites all copies from the voted value.
module uart_tx_core #(
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] TxData_i,
   input  logic                 TxValid_i,
   output logic                 TxReady_o,
   input  logic                 ParityEn_i,
   input  logic                 ParityOdd_i,
   input  logic                 SendSig_i,
   output logic                 Tx_o,
   output logic [4:0]           State_o,
   output logic [3:0]           BitCounter_o,
   output logic                 TxDone_o
);

   typedef enum logic [4:0] {
      ST_INTERVAL  = 5'b00001,
      ST_STARTBIT  = 5'b00010,
      ST_DATABITS  = 5'b00100,
      ST_PARITYBIT = 5'b01000,
      ST_STOPBIT   = 5'b10000
   } state_t;

   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS);
   localparam logic [1:0] LAST_STOP = 2'(STOP_BITS - 1);

   logic [4:0]           state0_q, state1_q, state2_q, state_v;
   logic [3:0]           bit_cnt0_q, bit_cnt1_q, bit_cnt2_q, bit_cnt_v, bit_cnt_d;
   logic [1:0]           stop_cnt0_q, stop_cnt1_q, stop_cnt2_q, stop_cnt_v, stop_cnt_d;
   logic [DATA_BITS-1:0] shift0_q, shift1_q, shift2_q, shift_v, shift_d;
   state_t               state_d;

   logic [DATA_BITS-1:0] hold_data_q;
   logic                 hold_par_en_q, hold_par_odd_q, pending_q, pending_d;
   logic                 frame_par_en_q, frame_par_q;
   logic                 tx_q, tx_d;
   logic                 accept, load, done, legal;

   assign state_v    = (state0_q & state1_q) | (state1_q & state2_q) | (state0_q & state2_q);
   assign bit_cnt_v  = (bit_cnt0_q & bit_cnt1_q) | (bit_cnt1_q & bit_cnt2_q) | (bit_cnt0_q & bit_cnt2_q);
   assign stop_cnt_v = (stop_cnt0_q & stop_cnt1_q) | (stop_cnt1_q & stop_cnt2_q) | (stop_cnt0_q & stop_cnt2_q);
   assign shift_v    = (shift0_q & shift1_q) | (shift1_q & shift2_q) | (shift0_q & shift2_q);

   assign accept = TxValid_i & ~pending_q;
   assign legal  = state_v inside {ST_INTERVAL, ST_STARTBIT, ST_DATABITS, ST_PARITYBIT, ST_STOPBIT};

   always_comb begin
      state_d    = state_t'(state_v);
      bit_cnt_d  = bit_cnt_v;
      stop_cnt_d = stop_cnt_v;
      shift_d    = shift_v;
      tx_d       = tx_q;
      load       = 1'b0;
      done       = 1'b0;
      if (!legal) begin
         state_d    = ST_INTERVAL;
         tx_d       = 1'b1;
         bit_cnt_d  = 4'd0;
         stop_cnt_d = 2'd0;
      end else if (SendSig_i) begin
         case (state_v)
            ST_INTERVAL: load = pending_q;
            ST_STARTBIT: begin
               state_d   = ST_DATABITS;
               tx_d      = shift_v[0];
               shift_d   = shift_v >> 1;
               bit_cnt_d = 4'd1;
            end
            ST_DATABITS: begin
               if (bit_cnt_v < LAST_DATA) begin
                  tx_d      = shift_v[0];
                  shift_d   = shift_v >> 1;
                  bit_cnt_d = bit_cnt_v + 4'd1;
               end else begin
                  bit_cnt_d  = 4'd0;
                  stop_cnt_d = 2'd0;
                  if (frame_par_en_q) begin
                     state_d = ST_PARITYBIT;
                     tx_d    = frame_par_q;
                  end else begin
                     state_d = ST_STOPBIT;
                     tx_d    = 1'b1;
                  end
               end
            end
            ST_PARITYBIT: begin
               state_d    = ST_STOPBIT;
               tx_d       = 1'b1;
               stop_cnt_d = 2'd0;
            end
            ST_STOPBIT: begin
               if (stop_cnt_v == LAST_STOP) begin
                  done       = 1'b1;
                  stop_cnt_d = 2'd0;
                  if (pending_q) begin
                     load = 1'b1;
                  end else begin
                     state_d = ST_INTERVAL;
                     tx_d    = 1'b1;
                  end
               end else begin
                  stop_cnt_d = stop_cnt_v + 2'd1;
               end
            end
            default: ;
         endcase
      end
      // Loading a frame overrides whichever state reached it (idle or final stop bit).
      if (load) begin
         state_d   = ST_STARTBIT;
         tx_d      = 1'b0;
         shift_d   = hold_data_q;
         bit_cnt_d = 4'd0;
      end
      pending_d = accept ? 1'b1 : (load ? 1'b0 : pending_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state0_q       <= ST_INTERVAL;
         state1_q       <= ST_INTERVAL;
         state2_q       <= ST_INTERVAL;
         bit_cnt0_q     <= '0;
         bit_cnt1_q     <= '0;
         bit_cnt2_q     <= '0;
         stop_cnt0_q    <= '0;
         stop_cnt1_q    <= '0;
         stop_cnt2_q    <= '0;
         shift0_q       <= '0;
         shift1_q       <= '0;
         shift2_q       <= '0;
         tx_q           <= 1'b1;
         pending_q      <= 1'b0;
         hold_data_q    <= '0;
         hold_par_en_q  <= 1'b0;
         hold_par_odd_q <= 1'b0;
         frame_par_en_q <= 1'b0;
         frame_par_q    <= 1'b0;
      end else begin
         state0_q    <= state_d;
         state1_q    <= state_d;
         state2_q    <= state_d;
         bit_cnt0_q  <= bit_cnt_d;
         bit_cnt1_q  <= bit_cnt_d;
         bit_cnt2_q  <= bit_cnt_d;
         stop_cnt0_q <= stop_cnt_d;
         stop_cnt1_q <= stop_cnt_d;
         stop_cnt2_q <= stop_cnt_d;
         shift0_q    <= shift_d;
         shift1_q    <= shift_d;
         shift2_q    <= shift_d;
         tx_q        <= tx_d;
         pending_q   <= pending_d;
         if (accept) begin
            hold_data_q    <= TxData_i;
            hold_par_en_q  <= ParityEn_i;
            hold_par_odd_q <= ParityOdd_i;
         end
         if (load) begin
            frame_par_en_q <= hold_par_en_q;
            frame_par_q    <= (^hold_data_q) ^ hold_par_odd_q;
         end
      end
   end

   assign TxReady_o    = ~pending_q;
   assign Tx_o         = tx_q;
   assign State_o      = state_v;
   assign BitCounter_o = bit_cnt_v;
   assign TxDone_o     = done;

endmodule
